// File: rtl/crc_frame_serializer_if.sv
// Capture and bit-serial transmit signals of crc_frame_serializer.
// master = serializer side, slave = CRC generator / line driver side.
interface crc_frame_serializer_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] crc;
  logic             crc_valid;
  logic             tx_ready;
  logic             tx_valid;
  logic             tx_bit;
  logic             tx_sof;
  logic             tx_eof;
  logic             busy;
  logic             overflow;
  logic [7:0]       frame_cnt;

  modport master (
    input  data, crc, crc_valid, tx_ready,
    output tx_valid, tx_bit, tx_sof, tx_eof, busy, overflow, frame_cnt
  );

  modport slave (
    output data, crc, crc_valid, tx_ready,
    input  tx_valid, tx_bit, tx_sof, tx_eof, busy, overflow, frame_cnt
  );
endinterface

// File: rtl/crc_frame_serializer.sv
// Serialises {data, crc} MSB first on each crc_valid strobe, with a one-entry pending buffer.
// Define CRC_SER_PREAMBLE_EN to prefix every frame with the PREAMBLE byte.
module crc_frame_serializer #(
  parameter int unsigned WIDTH = 16
`ifdef CRC_SER_PREAMBLE_EN
  , parameter logic [7:0] PREAMBLE = 8'hA5
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  crc_frame_serializer_if.master  bus
);

`ifdef CRC_SER_PREAMBLE_EN
  localparam int unsigned FrameLen = 2 * WIDTH + 8;
`else
  localparam int unsigned FrameLen = 2 * WIDTH;
`endif
  localparam int unsigned CntW = $clog2(FrameLen);
  localparam logic [CntW-1:0] LastCnt = CntW'(FrameLen - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e                 state_q, state_d;
  logic [FrameLen-1:0]    sreg_q, sreg_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     pend_q, pend_d;
  logic                   pend_valid_q, pend_valid_d;
  logic                   overflow_q, overflow_d;
  logic [7:0]             frame_cnt_q, frame_cnt_d;

  logic [2*WIDTH-1:0]     capture;
  logic                   xfer;
  logic                   last;

  function automatic logic [FrameLen-1:0] frame_word(input logic [2*WIDTH-1:0] payload);
`ifdef CRC_SER_PREAMBLE_EN
    return {PREAMBLE, payload};
`else
    return payload;
`endif
  endfunction

  assign capture = {bus.data, bus.crc};
  assign xfer    = (state_q == StShift) && bus.tx_ready;
  assign last    = xfer && (cnt_q == LastCnt);

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    overflow_d   = overflow_q;
    frame_cnt_d  = frame_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.crc_valid) begin
          sreg_d  = frame_word(capture);
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (last) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          cnt_d       = '0;
          if (pend_valid_q) begin
            // Pending frame follows with no gap; a same-edge capture refills the buffer.
            sreg_d       = frame_word(pend_q);
            pend_valid_d = bus.crc_valid;
            if (bus.crc_valid) pend_d = capture;
          end else if (bus.crc_valid) begin
            sreg_d = frame_word(capture);
          end else begin
            state_d = StIdle;
          end
        end else begin
          if (xfer) begin
            sreg_d = sreg_q << 1;
            cnt_d  = cnt_q + CntW'(1);
          end
          if (bus.crc_valid) begin
            if (!pend_valid_q) begin
              pend_d       = capture;
              pend_valid_d = 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sreg_q       <= '0;
      cnt_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      overflow_q   <= overflow_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign bus.tx_valid  = (state_q == StShift);
  assign bus.tx_bit    = bus.tx_valid & sreg_q[FrameLen-1];
  assign bus.tx_sof    = bus.tx_valid && (cnt_q == '0);
  assign bus.tx_eof    = bus.tx_valid && (cnt_q == LastCnt);
  assign bus.busy      = (state_q != StIdle) || pend_valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Self-checking bench for crc_frame_serializer: vector table, corner sequences and
// random traffic against a frame-queue reference model (capacity: current + one pending).
module tb_crc_frame_serializer;
  localparam int unsigned W = 16;
`ifdef CRC_SER_PREAMBLE_EN
  localparam int FLEN = 2 * W + 8;
`else
  localparam int FLEN = 2 * W;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crc_frame_serializer_if #(.WIDTH(W)) bus ();
  crc_frame_serializer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Reference model: queue of whole frames still owed to the line; head is on the wire.
  logic [63:0] m_q[$];
  int          m_pos;
  logic        m_ovf;
  logic [7:0]  m_cnt;
  bit          chk_en = 0;

  logic       obs_valid, obs_bit, obs_sof, obs_eof, obs_busy, obs_ovf;
  logic [7:0] obs_cnt;

  function automatic logic [63:0] fword(input logic [15:0] d, input logic [15:0] c);
`ifdef CRC_SER_PREAMBLE_EN
    return {24'd0, 8'hA5, d, c};
`else
    return {32'd0, d, c};
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_q.delete();
      m_pos = 0;
      m_ovf = 1'b0;
      m_cnt = 8'd0;
      return;
    end
    if (m_q.size() > 0 && bus.tx_ready) begin
      m_pos++;
      if (m_pos == FLEN) begin
        void'(m_q.pop_front());
        m_pos = 0;
        m_cnt = m_cnt + 8'd1;
      end
    end
    if (bus.crc_valid) begin
      if (m_q.size() < 2) m_q.push_back(fword(bus.data, bus.crc));
      else m_ovf = 1'b1;
    end
  endtask

  // Sample and check at negedge, advance model with the inputs seen by the next posedge.
  task automatic tick();
    logic [63:0] head;
    logic ev, eb;
    @(negedge clk);
    obs_valid = bus.tx_valid;
    obs_bit   = bus.tx_bit;
    obs_sof   = bus.tx_sof;
    obs_eof   = bus.tx_eof;
    obs_busy  = bus.busy;
    obs_ovf   = bus.overflow;
    obs_cnt   = bus.frame_cnt;
    if (chk_en) begin
      ev = (m_q.size() > 0);
      eb = 1'b0;
      if (ev) begin
        head = m_q[0];
        eb   = head[FLEN-1-m_pos];
      end
      chk("cycle{valid,bit,sof,eof,busy,ovf,cnt}",
          {obs_valid, obs_bit, obs_sof, obs_eof, obs_busy, obs_ovf, obs_cnt},
          {ev, eb, ev && m_pos == 0, ev && m_pos == FLEN - 1, ev, m_ovf, m_cnt});
    end
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [15:0] d, input logic [15:0] c);
    bus.data      = d;
    bus.crc       = c;
    bus.crc_valid = 1'b1;
    tick();
    bus.crc_valid = 1'b0;
  endtask

  task automatic drain();
    bus.tx_ready  = 1'b1;
    bus.crc_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!bus.busy) break;
      tick();
    end
    chk("drain_idle", bus.busy, 0);
  endtask

  typedef struct {
    logic [15:0] d;
    logic [15:0] c;
    int          div;        // tx_ready high on every div-th valid cycle
    int          exp_valid;  // cycles tx_valid stays high
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'hAAFF, 16'h1234, 1, FLEN};
    vecs[1] = '{16'hAAFF, 16'h1234, 2, 2 * FLEN};
    vecs[2] = '{16'h0000, 16'hFFFF, 3, 3 * FLEN};
    vecs[3] = '{16'h8001, 16'h7FFE, 1, FLEN};

    rst           = 1'b1;
    bus.data      = '0;
    bus.crc       = '0;
    bus.crc_valid = 1'b0;
    bus.tx_ready  = 1'b0;
    tick();
    chk_en = 1;
    tick();
    rst = 1'b0;
    chk("reset_frame_cnt", obs_cnt, 0);
    chk("reset_valid_busy", {obs_valid, obs_busy, obs_ovf}, 0);

    // Single frames with varying backpressure.
    for (int r = 0; r < 4; r++) begin
      logic [63:0] got;
      int nvalid;
      logic first_sof;
      bit done;
      got = 0;
      nvalid = 0;
      first_sof = 1'b0;
      done = 0;
      bus.tx_ready = 1'b0;
      capture(vecs[r].d, vecs[r].c);
      for (int k = 0; k < 400 && !done; k++) begin
        bus.tx_ready = ((k + 1) % vecs[r].div) == 0;
        tick();
        if (obs_valid) begin
          if (nvalid == 0) first_sof = obs_sof;
          nvalid++;
          if (bus.tx_ready) begin
            got = {got[62:0], obs_bit};
            if (obs_eof) done = 1;
          end
        end
      end
      chk($sformatf("row%0d_bits", r), got, fword(vecs[r].d, vecs[r].c));
      chk($sformatf("row%0d_valid_cycles", r), nvalid, vecs[r].exp_valid);
      chk($sformatf("row%0d_sof_first", r), first_sof, 1);
      tick();
      chk($sformatf("row%0d_frame_cnt", r), obs_cnt, r + 1);
      chk($sformatf("row%0d_busy_after", r), {obs_busy, obs_valid}, 0);
    end

    // Back-to-back: buffered frame starts right after the first eof.
    bus.tx_ready = 1'b1;
    capture(16'hAAFF, 16'h1234);
    repeat (5) tick();
    capture(16'hAAFE, 16'h5678);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (obs_eof) break;
    end
    tick();
    chk("b2b_sof_no_gap", {obs_valid, obs_sof}, 2'b11);
    drain();
    tick();
    chk("b2b_frame_cnt", obs_cnt, 6);
    chk("b2b_no_overflow", obs_ovf, 0);

    // Overflow: third capture during one frame is dropped.
    capture(16'h1111, 16'h2222);
    capture(16'h3333, 16'h4444);
    capture(16'h5555, 16'h6666);
    tick();
    chk("ovf_set", obs_ovf, 1);
    drain();
    tick();
    chk("ovf_sticky", obs_ovf, 1);
    chk("ovf_two_frames", obs_cnt, 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("ovf_cleared_by_rst", {obs_ovf, obs_cnt}, 0);

    // Reset mid-frame with pending full.
    capture(16'hC0DE, 16'hBEEF);
    capture(16'hFACE, 16'hCAFE);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_state", {obs_valid, obs_eof, obs_busy, obs_cnt}, 0);
    capture(16'h1357, 16'h2468);
    drain();
    tick();
    chk("midrst_next_frame", obs_cnt, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom % 400) == 0;
      bus.crc_valid = ($urandom % 6) == 0;
      bus.data      = 16'($urandom);
      bus.crc       = 16'($urandom);
      bus.tx_ready  = ($urandom % 4) != 0;
      tick();
    end
    rst = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/crc_frame_serializer.md
Name: crc_frame_serializer

Overview:
- Downstream stage of the CRC-16 generator.
- On each CRC-ready pulse it captures the data word and its CRC and transmits them as one serial frame, MSB first: data word, then CRC word.
- Output is a bit-serial valid/ready stream toward the line driver.
- A one-entry pending buffer absorbs a CRC result that arrives while a frame is still shifting out.

Parameters:
- WIDTH, 16: width of the data word and of the CRC word. The frame is 2*WIDTH bits, plus the preamble when enabled.
- PREAMBLE, 8'hA5: preamble byte. Used only when CRC_SER_PREAMBLE_EN is defined.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- data  in  WIDTH  payload word; sampled together with crc.
- crc  in  WIDTH  CRC of data; driven by the CRC generator's CRC output.
- crc_valid  in  1  one-cycle capture strobe; driven by the generator's out_ready_CRC.
- tx_ready  in  1  downstream accepts the current bit.
- tx_valid  out  1  tx_bit is valid.
- tx_bit  out  1  current serial bit.
- tx_sof  out  1  high with the first bit of a frame.
- tx_eof  out  1  high with the last bit of a frame.
- busy  out  1  high when state is not IDLE or the pending buffer is full.
- overflow  out  1  sticky flag: a capture was dropped.
- frame_cnt  out  8  count of completed frames; wraps 255 -> 0.

Behaviour:
- Reset values: rst=1 at a rising edge clears state to IDLE, shift register, bit counter, pending_valid, overflow and frame_cnt to 0. All outputs read 0 the following cycle. Reset mid-frame aborts the frame immediately; no eof is emitted and the pending entry is discarded.
- States: IDLE and SHIFT.
- IDLE:
  - tx_valid=0.
  - On an edge with crc_valid=1: load sreg={data,crc}, set cnt=0, go to SHIFT.
  - tx_valid rises in the next cycle (latency 1).
- SHIFT outputs:
  - tx_valid=1.
  - tx_bit=sreg[2*WIDTH-1].
  - tx_sof=(cnt==0).
  - tx_eof=(cnt==2*WIDTH-1).
- Bit transfer: a bit transfers on an edge with tx_valid and tx_ready both high. On transfer, sreg shifts left by 1 and cnt increments. With tx_ready=0, tx_bit, tx_sof, tx_eof and cnt hold.
- Last-bit transfer (tx_eof):
  - frame_cnt increments.
  - If pending_valid: load sreg from pending, clear pending_valid, set cnt=0, stay in SHIFT. There is no idle gap.
  - Else if crc_valid on the same edge: load directly from the inputs, stay in SHIFT.
  - Else go to IDLE.
- crc_valid while in SHIFT (not the last-bit transfer case above):
  - Pending empty: capture {data,crc} into pending and set pending_valid.
  - Pending full: drop the capture and set overflow=1. overflow clears only on rst.
- Last-bit transfer with pending full and crc_valid on the same edge: pending moves into sreg, and the new capture goes into pending. Nothing is dropped.
- busy is combinational from registered state. All other outputs are driven from registers or decoded from registered state and cnt; there are no combinational input-to-output paths except none.
- cnt width is clog2 of the frame length. It never exceeds the frame length minus 1.

Optional Feature:
- Macro: CRC_SER_PREAMBLE_EN.
- Defined:
  - Each frame is prefixed with the 8 bits of PREAMBLE, MSB first.
  - The frame length becomes 2*WIDTH+8 bits.
  - tx_sof marks the first preamble bit; tx_eof marks the last CRC bit.
  - The sreg is loaded as {PREAMBLE,data,crc}.
- Undefined: there is no preamble logic and the frame is exactly 2*WIDTH bits.
- All handshake, pending-buffer and overflow rules are identical in both builds.

Test Plan:
1. Single frame: rst for 2 cycles, then data=16'hAAFF, crc=16'h1234, crc_valid pulse, tx_ready=1 constant.
   - Expect tx_valid from the next cycle for 32 cycles.
   - Expect bits AAFF then 1234, MSB first, with sof on bit 0 and eof on bit 31.
   - Expect frame_cnt=1 and busy=0 afterward.
2. Backpressure: same frame, with tx_ready toggling 1,0,1,0.
   - Expect each bit held while tx_ready=0.
   - Expect the stream to match scenario 1 exactly, taking 64 cycles.
3. Back-to-back: second capture (16'hAAFE/16'h5678) pulsed mid-frame.
   - Expect it buffered and its sof on the cycle after the first eof, with no gap.
   - Expect frame_cnt=2 and overflow=0.
4. Overflow: three captures during one frame.
   - Expect the third capture dropped and overflow=1 and staying 1.
   - Expect only 2 frames sent.
   - Expect overflow cleared after rst.
5. Reset mid-frame: rst asserted at bit 10 with pending full.
   - Expect tx_valid=0, no eof, frame_cnt=0 and busy=0 on the next cycle.
   - Expect the next capture to transmit cleanly.
6. With CRC_SER_PREAMBLE_EN defined, scenario 1 stimulus:
   - Expect 40 bits: 10100101, then AAFF, then 1234.
   - Expect sof on the preamble MSB and eof on bit 39.
